// File: rtl/tl_drain_reader.sv
// tl_drain_reader: receive-side drain engine. Issues round-robin single-cycle
// pops to four output FIFOs, captures each popped word onto one tagged,
// valid-qualified stream, and keeps per-channel word counters readable via
// a req/idx handshake.
// Optional routing checker: define TL_DRAIN_CHECK_EN to build it. When it is
// undefined, err and err_ch are tied low.
module tl_drain_reader #(
    parameter int DATA_W = 10,
    parameter int CNT_W  = 5
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic              clear,
    input  logic              empty0,
    input  logic              empty1,
    input  logic              empty2,
    input  logic              empty3,
    input  logic [DATA_W-1:0] data_in0,
    input  logic [DATA_W-1:0] data_in1,
    input  logic [DATA_W-1:0] data_in2,
    input  logic [DATA_W-1:0] data_in3,
    output logic              pop0,
    output logic              pop1,
    output logic              pop2,
    output logic              pop3,
    output logic [DATA_W-1:0] data_out,
    output logic              data_valid,
    output logic [1:0]        data_ch,
    input  logic              req,
    input  logic [1:0]        idx,
    output logic [CNT_W-1:0]  contador,
    output logic              valid,
    output logic              err,
    output logic [1:0]        err_ch
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic [3:0]        empty_v;
    logic [DATA_W-1:0] data_in_v [4];

    logic [3:0]        pop_p0;
    logic [3:0]        pop_nxt;
    logic [1:0]        ptr;
    logic [3:0]        eligible;
    logic              grant_vld;
    logic [1:0]        grant_ch;
    logic              issue;

    logic              vld_p1;
    logic [1:0]        ch_p1;
    logic [DATA_W-1:0] word_p1;

    logic [CNT_W-1:0]  count [4];

    assign empty_v      = {empty3, empty2, empty1, empty0};
    assign data_in_v[0] = data_in0;
    assign data_in_v[1] = data_in1;
    assign data_in_v[2] = data_in2;
    assign data_in_v[3] = data_in3;
    assign {pop3, pop2, pop1, pop0} = pop_p0;

    // Word arriving this cycle from the channel popped last cycle
    assign word_p1 = data_in_v[ch_p1];

    // Round-robin pick: search starts one past the last granted channel
    // and wraps all the way round, so the last channel is checked last.
    function automatic logic [2:0] rr_pick(input logic [3:0] elig, input logic [1:0] last);
        logic [2:0] pick;
        logic [1:0] c;
        pick = 3'b000;
        for (int i = 1; i <= 4; i++) begin
            c = last + 2'(i);
            if (!pick[2] && elig[c]) begin
                pick = {1'b1, c};
            end
        end
        return pick;
    endfunction

    function automatic logic [1:0] onehot_ch(input logic [3:0] oh);
        logic [1:0] ch;
        ch = 2'd0;
        for (int k = 0; k < 4; k++) begin
            if (oh[k]) begin
                ch = 2'(k);
            end
        end
        return ch;
    endfunction

    // Arbitration: the channel popping right now is masked because its
    // empty flag does not yet reflect this pop.
    always_comb begin
        eligible              = ~empty_v & ~pop_p0;
        {grant_vld, grant_ch} = rr_pick(eligible, ptr);
    end

    // FSM next-state and pop decision
    always_comb begin
        state_nxt = state;
        issue     = 1'b0;
        pop_nxt   = 4'b0000;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (!enable) begin
                    state_nxt = DRAIN;
                end else if (grant_vld) begin
                    issue   = 1'b1;
                    pop_nxt = 4'b0001 << grant_ch;
                end
            end
            DRAIN: begin
                if (enable) begin
                    state_nxt = RUN;
                end else if (!vld_p1) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ---- stage p0: FSM state, registered pop strobes, round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            pop_p0 <= 4'b0000;
            ptr    <= 2'd3;
        end else begin
            state  <= state_nxt;
            pop_p0 <= pop_nxt;
            if (issue) begin
                ptr <= grant_ch;
            end
        end
    end

    // ---- stage p1: in-flight tag for the word the FIFO presents next cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
            ch_p1  <= 2'd0;
        end else begin
            vld_p1 <= |pop_p0;
            ch_p1  <= onehot_ch(pop_p0);
        end
    end

    // ---- stage p2: captured word onto the output stream
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_out   <= '0;
            data_ch    <= 2'd0;
            data_valid <= 1'b0;
        end else begin
            data_valid <= vld_p1;
            if (vld_p1) begin
                data_out <= word_p1;
                data_ch  <= ch_p1;
            end
        end
    end

    // Per-channel word counters; clear wins over a same-cycle capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < 4; k++) begin
                count[k] <= '0;
            end
        end else if (clear) begin
            for (int k = 0; k < 4; k++) begin
                count[k] <= '0;
            end
        end else if (vld_p1) begin
            count[ch_p1] <= count[ch_p1] + CNT_W'(1);
        end
    end

    // Counter read port: returns the value held in the request cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            contador <= '0;
            valid    <= 1'b0;
        end else begin
            valid <= req;
            if (req) begin
                contador <= count[idx];
            end
        end
    end

`ifdef TL_DRAIN_CHECK_EN
    logic mismatch;

    assign mismatch = vld_p1 && (word_p1[DATA_W-1 -: 2] != ch_p1);

    // Sticky routing-error flag; err_ch keeps the first offending channel
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err    <= 1'b0;
            err_ch <= 2'd0;
        end else if (clear) begin
            err <= 1'b0;
        end else if (mismatch) begin
            err <= 1'b1;
            if (!err) begin
                err_ch <= ch_p1;
            end
        end
    end
`else
    assign err    = 1'b0;
    assign err_ch = 2'd0;
`endif

endmodule

// File: tb/tb_tl_drain_reader.sv
// Bench for tl_drain_reader: FIFO models on all four channels, a per-cycle
// scoreboard driven by a queue/occupancy model of the drain rules, and
// directed scenarios with hand-computed literal expectations.
`timescale 1ns/1ps
module tb_tl_drain_reader;

    localparam int DATA_W  = 10;
    localparam int CNT_W   = 5;
    localparam int DEPTH   = 64;
    localparam int LOGN    = 80;
    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_DRAIN = 2;
`ifdef TL_DRAIN_CHECK_EN
    localparam int CHK = 1;
`else
    localparam int CHK = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset  = 1'b1;
    logic              enable = 1'b0;
    logic              clear  = 1'b0;
    logic              req    = 1'b0;
    logic [1:0]        idx    = 2'd0;
    logic [3:0]        empty;
    logic [DATA_W-1:0] din [4] = '{default: '0};
    logic              pop0, pop1, pop2, pop3;
    logic [3:0]        pop_v;
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic [1:0]        data_ch;
    logic [CNT_W-1:0]  contador;
    logic              valid;
    logic              err;
    logic [1:0]        err_ch;

    tl_drain_reader #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear(clear),
        .empty0(empty[0]), .empty1(empty[1]), .empty2(empty[2]), .empty3(empty[3]),
        .data_in0(din[0]), .data_in1(din[1]), .data_in2(din[2]), .data_in3(din[3]),
        .pop0(pop0), .pop1(pop1), .pop2(pop2), .pop3(pop3),
        .data_out(data_out), .data_valid(data_valid), .data_ch(data_ch),
        .req(req), .idx(idx), .contador(contador), .valid(valid),
        .err(err), .err_ch(err_ch)
    );

    assign pop_v = {pop3, pop2, pop1, pop0};

    // ---------------- FIFO models ----------------
    logic [DATA_W-1:0] mem [4][DEPTH];
    int wr [4] = '{default: 0};
    int rd [4] = '{default: 0};
    int underflow = 0;

    always_comb begin
        for (int k = 0; k < 4; k++) empty[k] = (rd[k] == wr[k]);
    end

    always @(posedge clk) begin
        for (int k = 0; k < 4; k++) begin
            if (pop_v[k]) begin
                if (rd[k] == wr[k]) underflow <= underflow + 1;
                else begin
                    din[k] <= mem[k][rd[k]];
                    rd[k]  <= rd[k] + 1;
                end
            end
        end
    end

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // e_* are the expected outputs for the current cycle; mp counts words the
    // model has taken out of each FIFO; t1 is the word popped one cycle ago.
    int                m_st    = S_IDLE;
    int                m_ptr   = 3;
    int                mp [4]  = '{default: 0};
    int                cnt [4] = '{default: 0};
    int                e_pop   = -1;
    logic [DATA_W-1:0] e_w     = '0;
    int                t1_ch   = -1;
    logic [DATA_W-1:0] t1_w    = '0;
    logic              e_dv    = 1'b0;
    logic [DATA_W-1:0] e_dout  = '0;
    int                e_dch   = 0;
    int                e_cont  = 0;
    logic              e_valid = 1'b0;
    logic              e_err   = 1'b0;
    int                e_errch = 0;

    always @(negedge clk) begin : scoreboard
        int                n_ch;
        logic [DATA_W-1:0] n_w;
        int                nxt;
        int                c;
        bit                inflight;
        if (reset) begin
            chk("rst pop", int'(pop_v), 0);
            chk("rst data_valid", int'(data_valid), 0);
            chk("rst data_out", int'(data_out), 0);
            chk("rst data_ch", int'(data_ch), 0);
            chk("rst contador", int'(contador), 0);
            chk("rst valid", int'(valid), 0);
            chk("rst err", int'(err), 0);
            chk("rst err_ch", int'(err_ch), 0);
            // a pop cancelled by reset never reaches its FIFO
            if (e_pop >= 0) mp[e_pop] = mp[e_pop] - 1;
            e_pop = -1; t1_ch = -1; m_st = S_IDLE; m_ptr = 3;
            e_dv = 1'b0; e_dout = '0; e_dch = 0; e_cont = 0; e_valid = 1'b0;
            e_err = 1'b0; e_errch = 0;
            for (int k = 0; k < 4; k++) cnt[k] = 0;
        end else begin
            chk("pop", int'(pop_v), (e_pop < 0) ? 0 : (1 << e_pop));
            chk("data_valid", int'(data_valid), int'(e_dv));
            chk("data_out", int'(data_out), int'(e_dout));
            chk("data_ch", int'(data_ch), e_dch);
            chk("valid", int'(valid), int'(e_valid));
            chk("contador", int'(contador), e_cont);
            chk("err", int'(err), int'(e_err));
            chk("err_ch", int'(err_ch), e_errch);
            chk("underflow", underflow, 0);

            // outputs for the next cycle
            n_ch = t1_ch; n_w = t1_w; inflight = (t1_ch >= 0);
            e_valid = req;
            if (req) e_cont = cnt[idx];
            if (clear) begin
                for (int k = 0; k < 4; k++) cnt[k] = 0;
                e_err = 1'b0;
            end else if (n_ch >= 0) begin
                cnt[n_ch] = (cnt[n_ch] + 1) % (1 << CNT_W);
                if (CHK == 1 && int'(n_w[DATA_W-1 -: 2]) != n_ch) begin
                    if (!e_err) e_errch = n_ch;
                    e_err = 1'b1;
                end
            end
            e_dv = (n_ch >= 0);
            if (e_dv) begin e_dout = n_w; e_dch = n_ch; end

            nxt = -1;
            if (m_st == S_RUN && enable) begin
                for (int i = 1; i <= 4; i++) begin
                    c = (m_ptr + i) % 4;
                    if (nxt < 0 && c != e_pop && wr[c] > mp[c]) nxt = c;
                end
            end
            case (m_st)
                S_IDLE:  if (enable) m_st = S_RUN;
                S_RUN:   if (!enable) m_st = S_DRAIN;
                default: if (enable) m_st = S_RUN; else if (!inflight) m_st = S_IDLE;
            endcase
            t1_ch = e_pop; t1_w = e_w;
            e_pop = nxt;
            if (nxt >= 0) begin
                e_w = mem[nxt][mp[nxt]];
                mp[nxt] = mp[nxt] + 1;
                m_ptr = nxt;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    int                pop_log [LOGN];
    bit                dv_log  [LOGN];
    logic [DATA_W-1:0] w_log   [LOGN];
    int                ch_log  [LOGN];
    bit                err_log [LOGN];
    int                ech_log [LOGN];

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic push(input int ch, input logic [DATA_W-1:0] w);
        mem[ch][wr[ch]] = w;
        wr[ch] = wr[ch] + 1;
    endtask

    task automatic record(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            pop_log[i] = int'(pop_v); dv_log[i] = data_valid; w_log[i] = data_out;
            ch_log[i] = int'(data_ch); err_log[i] = err; ech_log[i] = int'(err_ch);
        end
    endtask

    task automatic read_cnt(input int ch, input int exp, input string name);
        req = 1'b1; idx = 2'(ch);
        tick();
        req = 1'b0;
        chk({name, " valid"}, int'(valid), 1);
        chk(name, int'(contador), exp);
    endtask

    int exp_pop [4] = '{1, 4, 1, 4};
    logic [DATA_W-1:0] exp_w [4] = '{10'h005, 10'h205, 10'h006, 10'h206};
    int exp_ch [4] = '{0, 2, 0, 2};

    initial begin
        int  ndv;
        bit  found;
        // ---- reset, enable with everything empty
        repeat (3) tick();
        reset = 1'b0;
        enable = 1'b1;
        record(10);
        for (int i = 0; i < 10; i++) begin
            chk("idle pop", pop_log[i], 0);
            chk("idle data_valid", int'(dv_log[i]), 0);
        end
        tick();
        for (int k = 0; k < 4; k++) read_cnt(k, 0, "empty count");

        // ---- two channels interleave at full rate
        push(0, 10'h005); push(0, 10'h006);
        push(2, 10'h205); push(2, 10'h206);
        record(10);
        chk("rr pop before", pop_log[0], 0);
        for (int j = 0; j < 4; j++) begin
            chk("rr pop order", pop_log[1 + j], exp_pop[j]);
            chk("rr data_valid", int'(dv_log[3 + j]), 1);
            chk("rr data_out", int'(w_log[3 + j]), int'(exp_w[j]));
            chk("rr data_ch", ch_log[3 + j], exp_ch[j]);
        end
        chk("rr pop after", pop_log[5], 0);
        chk("rr data_valid after", int'(dv_log[7]), 0);
        tick();
        read_cnt(0, 2, "count0");
        read_cnt(2, 2, "count2");

        // ---- single channel: every other cycle
        push(3, 10'h3A1); push(3, 10'h3A2); push(3, 10'h3A3);
        record(10);
        for (int i = 0; i < 10; i++) begin
            chk("ch3 pop", pop_log[i], (i == 1 || i == 3 || i == 5) ? 8 : 0);
            chk("ch3 data_valid", int'(dv_log[i]), (i == 3 || i == 5 || i == 7) ? 1 : 0);
        end
        chk("ch3 third word", int'(w_log[7]), 10'h3A3);
        tick();
        read_cnt(3, 3, "count3");

        // ---- counter wrap and clear
        for (int i = 0; i < 33; i++) push(1, 10'(10'h100 + i));
        record(75);
        ndv = 0;
        for (int i = 0; i < 75; i++) ndv += int'(dv_log[i]);
        chk("ch1 words out", ndv, 33);
        tick();
        read_cnt(1, 1, "count1 wrapped");
        clear = 1'b1;
        tick();
        clear = 1'b0;
        read_cnt(1, 0, "count1 cleared");

        // ---- routing mismatches
        push(2, 10'h100);
        record(6);
        chk("mis1 data_valid", int'(dv_log[3]), 1);
        chk("mis1 data_out", int'(w_log[3]), 10'h100);
        chk("mis1 err before", int'(err_log[2]), 0);
        chk("mis1 err", int'(err_log[3]), CHK);
        chk("mis1 err_ch", ech_log[3], 2 * CHK);
        tick();
        push(0, 10'h2FF);
        record(6);
        chk("mis2 data_ch", ch_log[3], 0);
        chk("mis2 err", int'(err_log[3]), CHK);
        chk("mis2 err_ch", ech_log[3], 2 * CHK);
        tick();

        // ---- enable dropped one cycle after a pop
        push(0, 10'h0AB);
        tick();
        tick();
        enable = 1'b0;
        record(6);
        chk("drain data_valid", int'(dv_log[1]), 1);
        chk("drain data_out", int'(w_log[1]), 10'h0AB);
        for (int i = 0; i < 6; i++) chk("drain no pop", pop_log[i], 0);
        tick();
        read_cnt(0, 2, "count0 after drain");

        // ---- second run, reset mid-stream
        enable = 1'b1;
        for (int i = 0; i < 4; i++) push(1, 10'(10'h1C0 + i));
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if (data_valid) found = 1'b1;
        end
        chk("run2 first word seen", int'(found), 1);
        @(posedge clk); #1;
        reset = 1'b1;
        enable = 1'b0;
        #1;
        chk("mid rst pop", int'(pop_v), 0);
        chk("mid rst data_out", int'(data_out), 0);
        chk("mid rst data_valid", int'(data_valid), 0);
        chk("mid rst data_ch", int'(data_ch), 0);
        chk("mid rst contador", int'(contador), 0);
        chk("mid rst valid", int'(valid), 0);
        chk("mid rst err", int'(err), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        enable = 1'b1;
        record(8);
        chk("post rst pop0", pop_log[0], 0);
        chk("post rst pop1", pop_log[1], 0);
        chk("post rst pop2", pop_log[2], 2);
        chk("post rst pop3", pop_log[3], 0);
        chk("post rst pop4", pop_log[4], 2);
        chk("post rst pop5", pop_log[5], 0);
        repeat (3) tick();
        read_cnt(1, 2, "count1 after reset");
        repeat (2) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
